channel_prog_if: RTL and testbench

//  Bus-side programming and readback interface for one timer channel. It sits directly

---
 rtl/channel_prog_if.sv | 139 +++++++++++++
 tb/tb_channel_prog_if.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/channel_prog_if.sv
`default_nettype none
// ============================================================================
//  Module      : channel_prog_if
//  Description : Bus-side programming and counter-latch readback interface
//                for one 8253-style timer channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module channel_prog_if #(
    parameter logic [1:0] SEL = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic        rd,
    input  logic [1:0]  addr,
    input  logic [7:0]  din,
    input  logic [15:0] cnt_val,
    output logic [7:0]  dout,
    output logic        rd_valid,
    output logic [15:0] init_val,
    output logic        plmodif,
    output logic        plnif,
    output logic        p1,
    output logic        p2,
    output logic        os,
    output logic        plnact
);

    localparam logic [1:0] c_ADDR_CTRL = 2'b11;
    localparam logic [1:0] c_RL_LATCH  = 2'b00;
    localparam logic [1:0] c_RL_LSB    = 2'b01;
    localparam logic [1:0] c_RL_MSB    = 2'b10;

    logic [1:0]  r_rl;
    logic        r_wr_tog;
    logic        r_rd_tog;
    logic        r_latched;
    logic [15:0] r_lat;
    logic [7:0]  r_lsb_hold;

    logic        w_ctl_wr;
    logic        w_latch_cmd;
    logic        w_mode_wr;
    logic        w_cnt_wr;
    logic        w_rd;
    logic [2:0]  w_mode;
    logic [15:0] w_src;
    logic        w_rd_msb;
    logic        w_rd_last;

    assign w_ctl_wr    = wr && (addr == c_ADDR_CTRL) && (din[7:6] == SEL);
    assign w_latch_cmd = w_ctl_wr && (din[5:4] == c_RL_LATCH);
    // Modes 4..7 are not supported by the channel FSM, so those words are dropped whole.
    assign w_mode_wr   = w_ctl_wr && (din[5:4] != c_RL_LATCH) && !din[3];
    assign w_mode      = din[3:1];
    assign w_cnt_wr    = wr && (addr == SEL);
    // A simultaneous write wins; the read is discarded.
    assign w_rd        = rd && !wr && (addr == SEL);

    assign w_src     = r_latched ? r_lat : cnt_val;
    assign w_rd_msb  = (r_rl == c_RL_MSB) || ((r_rl == 2'b11) && r_rd_tog);
    assign w_rd_last = (r_rl != 2'b11) || r_rd_tog;

    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= 8'h00;
            rd_valid   <= 1'b0;
            init_val   <= 16'h0000;
            plmodif    <= 1'b0;
            plnif      <= 1'b0;
            p1         <= 1'b0;
            p2         <= 1'b0;
            os         <= 1'b0;
            plnact     <= 1'b1;
            r_rl       <= 2'b11;
            r_wr_tog   <= 1'b0;
            r_rd_tog   <= 1'b0;
            r_latched  <= 1'b0;
            r_lat      <= 16'h0000;
            r_lsb_hold <= 8'h00;
        end else begin
            plmodif  <= 1'b0;
            plnif    <= 1'b0;
            rd_valid <= 1'b0;

            if (w_latch_cmd) begin
                if (!r_latched) begin
                    r_lat     <= cnt_val;
                    r_latched <= 1'b1;
                end
            end else if (w_mode_wr) begin
                // A mode word also aborts any half-written count.
                r_rl      <= din[5:4];
                p1        <= (w_mode == 3'd2);
                p2        <= (w_mode == 3'd3);
                os        <= (w_mode == 3'd1);
                r_wr_tog  <= 1'b0;
                r_rd_tog  <= 1'b0;
                r_latched <= 1'b0;
                plnact    <= 1'b1;
                plmodif   <= 1'b1;
            end else if (w_cnt_wr) begin
                case (r_rl)
                    c_RL_LSB: begin
                        init_val <= {8'h00, din};
                        plnif    <= 1'b1;
                    end
                    c_RL_MSB: begin
                        init_val <= {din, 8'h00};
                        plnif    <= 1'b1;
                    end
                    default: begin
                        if (!r_wr_tog) begin
                            r_lsb_hold <= din;
                            r_wr_tog   <= 1'b1;
                            plnact     <= 1'b0;
                        end else begin
                            init_val <= {din, r_lsb_hold};
                            r_wr_tog <= 1'b0;
                            plnact   <= 1'b1;
                            plnif    <= 1'b1;
                        end
                    end
                endcase
            end else if (w_rd) begin
                dout     <= w_rd_msb ? w_src[15:8] : w_src[7:0];
                rd_valid <= 1'b1;
                if (r_rl == 2'b11) begin
                    r_rd_tog <= !r_rd_tog;
                end
                if (w_rd_last) begin
                    r_latched <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_channel_prog_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_channel_prog_if
//  Description : Directed self-checking bench for channel_prog_if.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_channel_prog_if;

    logic        clk;
    logic        reset;
    logic        wr;
    logic        rd;
    logic [1:0]  addr;
    logic [7:0]  din;
    logic [15:0] cnt_val;
    logic [7:0]  dout;
    logic        rd_valid;
    logic [15:0] init_val;
    logic        plmodif;
    logic        plnif;
    logic        p1;
    logic        p2;
    logic        os;
    logic        plnact;

    int total = 0;
    int bad   = 0;

    channel_prog_if #(.SEL(2'd0)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .rd       (rd),
        .addr     (addr),
        .din      (din),
        .cnt_val  (cnt_val),
        .dout     (dout),
        .rd_valid (rd_valid),
        .init_val (init_val),
        .plmodif  (plmodif),
        .plnif    (plnif),
        .p1       (p1),
        .p2       (p2),
        .os       (os),
        .plnact   (plnact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive for one clock edge; returns at the following falling edge.
    task automatic do_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        wr = 1'b1; addr = a; din = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic do_rd(input logic [1:0] a);
        @(negedge clk);
        rd = 1'b1; addr = a;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dout"},     {24'h0, dout}, 32'h00);
        check({tag, "_rdv"},      {31'h0, rd_valid}, 32'h0);
        check({tag, "_init"},     {16'h0, init_val}, 32'h0000);
        check({tag, "_plmodif"},  {31'h0, plmodif}, 32'h0);
        check({tag, "_plnif"},    {31'h0, plnif}, 32'h0);
        check({tag, "_mode"},     {29'h0, p1, p2, os}, 32'h0);
        check({tag, "_plnact"},   {31'h0, plnact}, 32'h1);
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = 2'd0; din = 8'h00; cnt_val = 16'h0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_state("rst");

        // Mode word: RL=11, M=2
        do_wr(2'd3, 8'h34);
        check("t1_plmodif", {31'h0, plmodif}, 32'h1);
        check("t1_mode", {29'h0, p1, p2, os}, 32'b100);
        idle();
        check("t1_plmodif_off", {31'h0, plmodif}, 32'h0);

        // Two-byte count
        do_wr(2'd0, 8'hCD);
        check("t2_plnact_lo", {31'h0, plnact}, 32'h0);
        check("t2_init_hold", {16'h0, init_val}, 32'h0000);
        check("t2_plnif_lo", {31'h0, plnif}, 32'h0);
        do_wr(2'd0, 8'hAB);
        check("t2_plnif", {31'h0, plnif}, 32'h1);
        check("t2_init", {16'h0, init_val}, 32'hABCD);
        check("t2_plnact", {31'h0, plnact}, 32'h1);
        idle();
        check("t2_plnif_off", {31'h0, plnif}, 32'h0);

        // Latch readback
        cnt_val = 16'h1234;
        do_wr(2'd3, 8'h00);
        cnt_val = 16'h1111;
        do_rd(2'd0);
        check("t3_lsb", {24'h0, dout}, 32'h34);
        check("t3_rdv1", {31'h0, rd_valid}, 32'h1);
        do_rd(2'd0);
        check("t3_msb", {24'h0, dout}, 32'h12);
        check("t3_rdv2", {31'h0, rd_valid}, 32'h1);
        idle();
        check("t3_rdv_off", {31'h0, rd_valid}, 32'h0);
        do_rd(2'd0);
        check("t3_live_lsb", {24'h0, dout}, 32'h11);
        do_rd(2'd0);

        // Latch command mid read sequence keeps rd_tog
        cnt_val = 16'h5678;
        do_rd(2'd0);
        check("t3b_live_lsb", {24'h0, dout}, 32'h78);
        do_wr(2'd3, 8'h00);
        cnt_val = 16'h9999;
        do_rd(2'd0);
        check("t3b_lat_msb", {24'h0, dout}, 32'h56);
        do_rd(2'd0);
        check("t3b_live_after", {24'h0, dout}, 32'h99);
        do_rd(2'd0);

        // Abort half-written count with a mode word (RL=01, M=1)
        do_wr(2'd0, 8'h55);
        check("t4_plnact_lo", {31'h0, plnact}, 32'h0);
        do_wr(2'd3, 8'h12);
        check("t4_plnact", {31'h0, plnact}, 32'h1);
        check("t4_mode", {29'h0, p1, p2, os}, 32'b001);
        check("t4_init_keep", {16'h0, init_val}, 32'hABCD);
        check("t4_plnif_none", {31'h0, plnif}, 32'h0);
        check("t4_plmodif", {31'h0, plmodif}, 32'h1);
        idle();
        check("t4_plnif_none2", {31'h0, plnif}, 32'h0);
        do_wr(2'd0, 8'h07);
        check("t4_init_lsb", {16'h0, init_val}, 32'h0007);
        check("t4_plnif", {31'h0, plnif}, 32'h1);
        cnt_val = 16'hBEEF;
        do_rd(2'd0);
        check("t4_rd_lsb", {24'h0, dout}, 32'hEF);
        do_rd(2'd0);
        check("t4_rd_lsb2", {24'h0, dout}, 32'hEF);

        // Ignore rules
        do_wr(2'd3, 8'h3A);
        check("t5_m5_plmodif", {31'h0, plmodif}, 32'h0);
        check("t5_m5_mode", {29'h0, p1, p2, os}, 32'b001);
        do_rd(2'd0);
        check("t5_m5_rl", {24'h0, dout}, 32'hEF);
        do_wr(2'd3, 8'h70);
        check("t5_sc_plmodif", {31'h0, plmodif}, 32'h0);
        do_wr(2'd0, 8'h22);
        check("t5_sc_rl", {16'h0, init_val}, 32'h0022);
        @(negedge clk);
        wr = 1'b1; rd = 1'b1; addr = 2'd0; din = 8'h33;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        check("t5_wrrd_rdv", {31'h0, rd_valid}, 32'h0);
        check("t5_wrrd_init", {16'h0, init_val}, 32'h0033);
        check("t5_wrrd_plnif", {31'h0, plnif}, 32'h1);
        do_rd(2'd3);
        check("t5_rd3_rdv", {31'h0, rd_valid}, 32'h0);

        // RL=10, M=0
        do_wr(2'd3, 8'h20);
        check("t5b_mode", {29'h0, p1, p2, os}, 32'b000);
        check("t5b_plmodif", {31'h0, plmodif}, 32'h1);
        do_wr(2'd0, 8'h9A);
        check("t5b_init_msb", {16'h0, init_val}, 32'h9A00);
        do_rd(2'd0);
        check("t5b_rd_msb", {24'h0, dout}, 32'hBE);

        // Reset mid half-load
        do_wr(2'd3, 8'h36);
        check("t6_mode", {29'h0, p1, p2, os}, 32'b010);
        do_wr(2'd0, 8'h11);
        check("t6_plnact_lo", {31'h0, plnact}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("t6");
        do_wr(2'd0, 8'h44);
        check("t6_first_lsb", {31'h0, plnact}, 32'h0);
        check("t6_init_hold", {16'h0, init_val}, 32'h0000);
        do_wr(2'd0, 8'h55);
        check("t6_init", {16'h0, init_val}, 32'h5544);
        check("t6_plnif", {31'h0, plnif}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
